display_spi_tx: RTL and testbench

- Write-only SPI master that shifts one 16-bit word, MSB first, to an external display controller.
- Sits beside the memory/I-O block: an I/O write loads the word and pulses or holds `start`; software polls `busy` through an I/O read.
- Generates `cs`, `sclk` and `mosi` from the fast `raw_clk` with a programmable half-period divider.

---
 rtl/display_spi_if_if.sv | 11 +
 rtl/display_spi_tx.sv | 88 ++++++++
 tb/tb_display_spi_tx.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/display_spi_if_if.sv
// display_spi_if: host-side request and SPI pin bundle for display_spi_tx.
interface display_spi_if;
    logic        start;
    logic [15:0] data_tx;
    logic        busy;
    logic        cs;
    logic        sclk;
    logic        mosi;
    modport master (output start, data_tx, input busy, cs, sclk, mosi);
    modport slave (input start, data_tx, output busy, cs, sclk, mosi);
endinterface

// File: rtl/display_spi_tx.sv
// display_spi_tx: write-only mode-0 SPI master sending one 16-bit word MSB first.
module display_spi_tx #(
    parameter int unsigned HALF_PERIOD = 4
) (
    input logic             raw_clk,
    input logic             reset,
    display_spi_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP} state_t;
    state_t      state, state_n;
    logic [7:0]  div, div_n;
    logic [3:0]  bit_cnt, bit_n;
    logic [15:0] sh, sh_n;
    logic        start_q;
    logic        cs_q, cs_n, sclk_q, sclk_n, mosi_q, mosi_n, busy_q, busy_n;
    logic        last;
    assign last = div == 8'(HALF_PERIOD - 1);
    assign bus.cs = cs_q;
    assign bus.sclk = sclk_q;
    assign bus.mosi = mosi_q;
    assign bus.busy = busy_q;
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state   <= IDLE;
            div     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            start_q <= 1'b1;
            cs_q    <= 1'b1;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            div     <= div_n;
            bit_cnt <= bit_n;
            sh      <= sh_n;
            start_q <= bus.start;
            cs_q    <= cs_n;
            sclk_q  <= sclk_n;
            mosi_q  <= mosi_n;
            busy_q  <= busy_n;
        end
    end
    // Shifting in zeros makes sh[14] read 0 after the last bit, parking mosi low.
    always_comb begin
        state_n = state;
        div_n   = (state == IDLE || last) ? 8'd0 : div + 8'd1;
        bit_n   = bit_cnt;
        sh_n    = sh;
        cs_n    = cs_q;
        sclk_n  = sclk_q;
        mosi_n  = mosi_q;
        busy_n  = busy_q;
        unique case (state)
            IDLE: if (bus.start && !start_q) begin
                state_n = SETUP;
                sh_n    = bus.data_tx;
                bit_n   = '0;
                busy_n  = 1'b1;
                cs_n    = 1'b0;
                sclk_n  = 1'b0;
                mosi_n  = bus.data_tx[15];
            end
            SETUP: if (last) begin
                state_n = SHIFT_HI;
                sclk_n  = 1'b1;
            end
            SHIFT_HI: if (last) begin
                state_n = SHIFT_LO;
                sclk_n  = 1'b0;
                sh_n    = {sh[14:0], 1'b0};
                mosi_n  = sh[14];
            end
            SHIFT_LO: if (last) begin
                state_n = (bit_cnt == 4'd15) ? GAP : SHIFT_HI;
                cs_n    = bit_cnt == 4'd15;
                sclk_n  = bit_cnt != 4'd15;
                bit_n   = bit_cnt + 4'd1;
            end
            GAP: if (last) begin
                state_n = IDLE;
                busy_n  = 1'b0;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_display_spi_tx.sv
// tb_display_spi_tx: checks two display_spi_tx instances (H=4, H=1) against a timeline model.
module tb_display_spi_tx;
    logic raw_clk = 1'b0;
    logic reset;
    always #5 raw_clk = ~raw_clk;
    display_spi_if bus4 ();
    display_spi_if bus1 ();
    display_spi_tx #(.HALF_PERIOD(4)) dut4 (.raw_clk(raw_clk), .reset(reset), .bus(bus4.slave));
    display_spi_tx #(.HALF_PERIOD(1)) dut1 (.raw_clk(raw_clk), .reset(reset), .bus(bus1.slave));
    int asserts = 0, fails = 0;
    bit armed = 0;
    int hp [2] = '{4, 1};
    logic [3:0]  o [2];
    logic        st [2];
    logic [15:0] dt [2];
    assign o[0] = {bus4.busy, bus4.cs, bus4.sclk, bus4.mosi};
    assign o[1] = {bus1.busy, bus1.cs, bus1.sclk, bus1.mosi};
    assign st[0] = bus4.start;
    assign st[1] = bus1.start;
    assign dt[0] = bus4.data_tx;
    assign dt[1] = bus1.data_tx;
    task automatic chk(string n, int a, int e);
        asserts++;
        if (a != e) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask
    // Model: t counts output cycles since acceptance (0 = idle); outputs follow from t alone.
    int          t [2] = '{0, 0};
    logic [15:0] word [2];
    logic        prev [2];
    function automatic logic [3:0] expv(int tt, logic [15:0] w, int h);
        int p, k;
        if (tt == 0) return 4'b0100;
        p = (tt - 1) / h;
        if (p == 0) return {3'b100, w[15]};
        if (p == 33) return 4'b1100;
        k = (p - 1) / 2;
        if ((p - 1) % 2 == 0) return {3'b101, w[15-k]};
        return (k < 15) ? {3'b100, w[14-k]} : 4'b1000;
    endfunction
    always @(posedge raw_clk)
        for (int i = 0; i < 2; i++)
            if (reset) begin
                t[i] <= 0;
                prev[i] <= 1'b1;
            end else begin
                prev[i] <= st[i];
                if (t[i] == 0) begin
                    if (st[i] && !prev[i]) begin
                        t[i] <= 1;
                        word[i] <= dt[i];
                    end
                end else
                    t[i] <= (t[i] == 34 * hp[i]) ? 0 : t[i] + 1;
            end
    int          edges [2], csl [2], bsy [2], cs_run [2], last_gap [2];
    logic [15:0] rx [2];
    logic        sprev [2];
    always @(negedge raw_clk) begin
        for (int i = 0; i < 2; i++) begin
            if (armed) chk($sformatf("outputs[%0d] {busy,cs,sclk,mosi}", i), int'(o[i]), int'(expv(t[i], word[i], hp[i])));
            if (o[i][1] && !sprev[i]) begin
                rx[i] = {rx[i][14:0], o[i][0]};
                edges[i]++;
            end
            sprev[i] = o[i][1];
            if (!o[i][2]) csl[i]++;
            if (o[i][3]) bsy[i]++;
            if (o[i][2]) cs_run[i]++;
            else begin
                if (cs_run[i] > 0) last_gap[i] = cs_run[i];
                cs_run[i] = 0;
            end
        end
    end
    task automatic tick();
        @(posedge raw_clk);
        #2;
    endtask
    task automatic clear(int i);
        rx[i] = 0;
        edges[i] = 0;
        csl[i] = 0;
        bsy[i] = 0;
    endtask
    task automatic set_in(int i, logic s, logic [15:0] d);
        if (i == 0) begin
            bus4.start = s;
            bus4.data_tx = d;
        end else begin
            bus1.start = s;
            bus1.data_tx = d;
        end
    endtask
    task automatic pulse(int i, logic [15:0] d);
        set_in(i, 1'b1, d);
        tick();
        set_in(i, 1'b0, d);
    endtask
    task automatic wait_done(int i);
        int n = 0;
        while (o[i][3] && n < 400) begin
            tick();
            n++;
        end
        chk("wait_done timeout", int'(n < 400), 1);
    endtask
    logic [15:0] r1;
    initial begin
        reset = 1'b1;
        set_in(0, 1'b1, 16'h0000);
        set_in(1, 1'b0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            clear(i);
            sprev[i] = 1'b0;
            cs_run[i] = 0;
            last_gap[i] = 0;
        end
        tick();
        armed = 1;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("start held through reset busy", int'(o[0][3]), 0);
        set_in(0, 1'b0, 16'h0000);
        tick();
        clear(0);
        pulse(0, 16'hA55A);
        chk("accept latency busy,cs", int'(o[0][3:2]), 2'b10);
        chk("accept mosi bit15", int'(o[0][0]), 1);
        wait_done(0);
        repeat (3) tick();
        chk("A55A word", int'(rx[0]), 16'hA55A);
        chk("A55A edges", edges[0], 16);
        chk("A55A cs low", csl[0], 132);
        chk("A55A busy high", bsy[0], 136);
        clear(0);
        set_in(0, 1'b1, 16'h0001);
        repeat (300) tick();
        set_in(0, 1'b0, 16'h0001);
        tick();
        chk("held start word", int'(rx[0]), 16'h0001);
        chk("held start edges", edges[0], 16);
        chk("held start busy high", bsy[0], 136);
        clear(0);
        pulse(0, 16'hFFFF);
        repeat (40) tick();
        pulse(0, 16'h0000);
        wait_done(0);
        repeat (5) tick();
        chk("FFFF word", int'(rx[0]), 16'hFFFF);
        chk("FFFF edges", edges[0], 16);
        chk("FFFF busy high", bsy[0], 136);
        clear(0);
        pulse(0, 16'h3C3C);
        for (int n = 0; n < 200 && edges[0] < 8; n++) tick();
        chk("reached 8th sclk high", edges[0], 8);
        chk("sclk high before reset", int'(o[0][1]), 1);
        reset = 1'b1;
        tick();
        chk("mid reset {busy,cs,sclk,mosi}", int'(o[0]), 4'b0100);
        reset = 1'b0;
        tick();
        clear(0);
        pulse(0, 16'hC3A5);
        wait_done(0);
        chk("post reset word", int'(rx[0]), 16'hC3A5);
        chk("post reset edges", edges[0], 16);
        clear(0);
        pulse(0, 16'h1234);
        wait_done(0);
        r1 = rx[0];
        clear(0);
        pulse(0, 16'hFEDC);
        wait_done(0);
        chk("b2b first word", int'(r1), 16'h1234);
        chk("b2b second word", int'(rx[0]), 16'hFEDC);
        chk("b2b second edges", edges[0], 16);
        chk("b2b cs high gap", last_gap[0], 5);
        tick();
        clear(1);
        pulse(1, 16'h8001);
        wait_done(1);
        tick();
        chk("H1 word", int'(rx[1]), 16'h8001);
        chk("H1 edges", edges[1], 16);
        chk("H1 busy high", bsy[1], 34);
        chk("H1 cs low", csl[1], 33);
        repeat (4) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
